// File: rtl/mem_dp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered reads,
// selectable read-during-write policy and a post-reset sequential zero-clear engine.
module mem_dp_be #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     init_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("mem_dp_be: WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("mem_dp_be: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_dp_be: DEPTH must be a power of two >= 4");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [AW-1:0]   clr_addr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic            wr_ok;
  logic            rd_ok;
  logic            clr_we;
  logic [WIDTH-1:0] data_p0;
  logic            vld_p0;

  // User requests are dropped while the clear engine owns the array.
  assign wr_ok  = wr_en & ~init_busy & rstn;
  assign rd_ok  = rd_en & ~init_busy & rstn;
  assign clr_we = (state == CLEAR) & rstn;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      clr_addr  <= '0;
      init_busy <= (CLEAR_ON_RST != 0);
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == AW'(DEPTH - 1)) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-through mode forwards the merged word on a same-address collision.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE != 0 && wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Stage p0: array read
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_ok;
      if (rd_ok) data_p0 <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    // Stage p1: extra output register
    always_ff @(posedge clk) begin
      if (!rstn) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end

    assign rd_data  = data_p1;
    assign rd_valid = vld_p1;
  end else begin : g_lat1
    assign rd_data  = data_p0;
    assign rd_valid = vld_p0;
  end

endmodule

// File: tb/tb_mem_dp_be.sv
// Bench for mem_dp_be: directed vector table on 32x256 builds (RD_LAT 1/2, both
// collision modes), reset/clear sequences, and a randomized 64x16 sweep vs a model.
module tb_mem_dp_be;
  logic clk;
  logic rstn;

  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  logic        cwr_en, crd_en;
  logic [3:0]  cwr_addr, crd_addr;
  logic [63:0] cwr_data;
  logic [7:0]  cwr_be;
  logic [63:0] rd_data_c, rd_data_d;
  logic        rd_valid_c, rd_valid_d, busy_c, busy_d;

  int total = 0;
  int bad   = 0;

  mem_dp_be u_a (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .init_busy(busy_a));

  mem_dp_be #(.RD_LAT(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .init_busy(busy_b));

  mem_dp_be #(.WIDTH(64), .DEPTH(16), .RD_LAT(1), .RDW_MODE(1)) u_c (
    .clk(clk), .rstn(rstn), .wr_en(cwr_en), .wr_addr(cwr_addr), .wr_data(cwr_data),
    .wr_be(cwr_be), .rd_en(crd_en), .rd_addr(crd_addr), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .init_busy(busy_c));

  mem_dp_be #(.WIDTH(64), .DEPTH(16), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RST(0)) u_d (
    .clk(clk), .rstn(rstn), .wr_en(cwr_en), .wr_addr(cwr_addr), .wr_data(cwr_data),
    .wr_be(cwr_be), .rd_en(crd_en), .rd_addr(crd_addr), .rd_data(rd_data_d),
    .rd_valid(rd_valid_d), .init_busy(busy_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [7:0]  ra;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_ab();
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  // Called at a negedge; A answers one cycle later, B two cycles later.
  task automatic apply_vec(input vec_t v, input string name);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; wr_be = v.be;
    rd_en = v.re; rd_addr = v.ra;
    @(negedge clk);
    check({name, "_vld_a"}, 64'(rd_valid_a), 64'(v.re));
    if (v.re) check({name, "_data_a"}, 64'(rd_data_a), 64'(v.exp_a));
    idle_ab();
    @(negedge clk);
    check({name, "_vld_b"}, 64'(rd_valid_b), 64'(v.re));
    if (v.re) check({name, "_data_b"}, 64'(rd_data_b), 64'(v.exp_b));
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  vec_t        vecs[16];
  logic [63:0] ref_mem[16];
  logic [63:0] exp_q[$];
  int          cnt_a, cnt_b, cnt_c, vld_seen, accepted, vcount_c, vcount_d;
  logic [63:0] expd;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h80, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'hFF, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h10, 32'hAA22CC44, 32'hAA22CC44};
    vecs[6]  = '{1'b1, 8'h07, 32'h0000FFFF, 4'hF, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 8'h07, 32'h12345678, 4'hF, 1'b1, 8'h07, 32'h0000FFFF, 32'h12345678};
    vecs[8]  = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h07, 32'h12345678, 32'h12345678};
    vecs[9]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h08, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 8'h09, 32'hDEADBEEF, 4'hA, 1'b1, 8'h09, 32'h0,        32'hDE00BE00};
    vecs[11] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 8'h09, 32'hDE00BE00, 32'hDE00BE00};
    vecs[12] = '{1'b1, 8'h01, 32'h1,        4'hF, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 8'h02, 32'h2,        4'hF, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 8'h03, 32'h3,        4'hF, 1'b0, 8'h00, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 8'h04, 32'h4,        4'hF, 1'b0, 8'h00, 32'h0,        32'h0};

    rstn = 1'b0;
    idle_ab();
    cwr_en = 1'b0; crd_en = 1'b0; cwr_addr = '0; crd_addr = '0; cwr_data = '0; cwr_be = '0;

    // Power-on reset held 3 cycles, then count busy cycles from release.
    repeat (3) @(negedge clk);
    check("rst_busy_a", 64'(busy_a), 64'd1);
    check("rst_busy_d", 64'(busy_d), 64'd0);
    check("rst_vld_a", 64'(rd_valid_a), 64'd0);
    check("rst_data_a", 64'(rd_data_a), 64'd0);
    check("rst_data_c", rd_data_c, 64'd0);
    rstn = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (busy_c) cnt_c++;
      @(negedge clk);
    end
    check("clear_cycles_a", 64'(cnt_a), 64'd256);
    check("clear_cycles_b", 64'(cnt_b), 64'd256);
    check("clear_cycles_c", 64'(cnt_c), 64'd16);
    check("busy_done_a", 64'(busy_a), 64'd0);
    check("busy_d_after", 64'(busy_d), 64'd0);

    for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("row%0d", i));

    // Back-to-back reads of addresses 1..4.
    rd_en = 1'b1; rd_addr = 8'd1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_vld_a%0d", k), 64'(rd_valid_a), 64'(k < 4));
      if (k < 4) check($sformatf("b2b_data_a%0d", k), 64'(rd_data_a), 64'(k + 1));
      else       check($sformatf("b2b_hold_a%0d", k), 64'(rd_data_a), 64'd4);
      check($sformatf("b2b_vld_b%0d", k), 64'(rd_valid_b), 64'(k >= 1 && k < 5));
      if (k >= 1 && k < 5) check($sformatf("b2b_data_b%0d", k), 64'(rd_data_b), 64'(k));
      if (k < 3) rd_addr = 8'(k + 2);
      else       rd_en = 1'b0;
    end
    idle_ab();

    // Reset, then a second reset 100 cycles into the clear.
    rstn = 1'b0;
    @(negedge clk);
    check("rerst_data_a", 64'(rd_data_a), 64'd0);
    check("rerst_data_b", 64'(rd_data_b), 64'd0);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    check("midclear_busy", 64'(busy_a), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cnt_a = 0; cnt_b = 0; vld_seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (rd_valid_a || rd_valid_b) vld_seen++;
      if (cyc == 50) begin
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd5;
      end else begin
        idle_ab();
      end
      @(negedge clk);
    end
    check("reclear_cycles_a", 64'(cnt_a), 64'd256);
    check("reclear_cycles_b", 64'(cnt_b), 64'd256);
    check("busy_rd_ignored", 64'(vld_seen), 64'd0);
    apply_vec('{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h05, 32'h0, 32'h0}, "busy_wr_ignored");
    apply_vec('{1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 8'h07, 32'h0, 32'h0}, "reclear_addr7");

    // Randomized sweep on the 64x16 write-through build against a plain array model.
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    accepted = 0; vcount_c = 0; vcount_d = 0;
    for (int cyc = 0; cyc < 2003; cyc++) begin
      if (rd_valid_c) begin
        vcount_c++;
        if (exp_q.size() == 0) check("sweep_extra_valid", 64'd1, 64'd0);
        else begin
          expd = exp_q.pop_front();
          check($sformatf("sweep_rd%0d", cyc), rd_data_c, expd);
        end
      end
      if (rd_valid_d) vcount_d++;
      if (cyc < 2000) begin
        cwr_en   = 1'($urandom_range(0, 1));
        cwr_addr = 4'($urandom_range(0, 15));
        cwr_data = {$urandom, $urandom};
        cwr_be   = 8'($urandom);
        crd_en   = 1'($urandom_range(0, 1));
        crd_addr = ($urandom_range(0, 3) == 0) ? cwr_addr : 4'($urandom_range(0, 15));
        if (crd_en) begin
          accepted++;
          if (cwr_en && cwr_addr == crd_addr)
            exp_q.push_back(merge(ref_mem[crd_addr], cwr_data, cwr_be));
          else
            exp_q.push_back(ref_mem[crd_addr]);
        end
        if (cwr_en) ref_mem[cwr_addr] = merge(ref_mem[cwr_addr], cwr_data, cwr_be);
      end else begin
        cwr_en = 1'b0; crd_en = 1'b0;
      end
      @(negedge clk);
    end
    check("sweep_queue_empty", 64'(exp_q.size()), 64'd0);
    check("sweep_valid_count_c", 64'(vcount_c), 64'(accepted));
    check("sweep_valid_count_d", 64'(vcount_d), 64'(accepted));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dp_be.md
Name: mem_dp_be

Overview:
- Parametrised simple-dual-port memory: one write port with byte enables, one independent read port.
- Programmable read latency and read-during-write policy.
- Bulk zero-clear after every reset is performed by a sequential clear engine, since a synchronous reset cannot clear the whole array in one cycle.
- Serves as the general on-chip storage block for datapath and verification-environment memories; the write path and read path are decoupled.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; power of two, ≥ 4.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- RDW_MODE, 0, same-address read/write collision policy: 0 = read-old, 1 = write-through (new data).
- CLEAR_ON_RST, 1, 1 = zero the array after reset; 0 = no clear, contents undefined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  $clog2(DEPTH)  write address.
- wr_data  in  WIDTH  write data.
- wr_be  in  WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  $clog2(DEPTH)  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high.
- init_busy  out  1  clear in progress; requests are ignored while it is high.

Behaviour:
- Reset (rstn=0 sampled at posedge):
  - rd_data=0, rd_valid=0, read pipeline flushed.
  - Clear FSM goes to CLEAR with clr_addr=0.
  - init_busy=1 if CLEAR_ON_RST=1, else 0.
- Clear FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to mem[clr_addr], then clr_addr+1.
  - After writing DEPTH-1 the FSM moves to READY; init_busy falls on the next cycle.
  - With CLEAR_ON_RST=1, init_busy is high for exactly DEPTH cycles after the first cycle with rstn=1.
  - With CLEAR_ON_RST=0, the FSM goes directly to READY.
- Reset asserted mid-clear: the clear restarts from address 0 and the full DEPTH-cycle clear repeats.
- Requests while init_busy=1:
  - wr_en and rd_en are ignored; no array update and no rd_valid.
  - The issuer must wait for init_busy=0.
- Write (wr_en=1, READY):
  - At the posedge, for each i with wr_be[i]=1, mem[wr_addr] byte i takes wr_data byte i; other bytes are unchanged.
  - wr_be=0 means no change.
- Read (rd_en=1, READY):
  - RD_LAT=1: rd_data=mem[rd_addr] and rd_valid=1 in the cycle after the request.
  - RD_LAT=2: the same data, one cycle later.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- rd_data holds its last value when rd_valid=0.
- Collision (wr_en & rd_en, wr_addr==rd_addr, same cycle):
  - RDW_MODE=0: read returns pre-write contents.
  - RDW_MODE=1: read returns the merged result (new bytes where wr_be=1, old bytes elsewhere).
- Write and read to different addresses in the same cycle are independent.
- Addresses are always in range (power-of-two DEPTH); no wrap logic beyond natural truncation.
- Out-of-range RD_LAT or WIDTH%8≠0 is an elaboration error.

Test Plan:
- Reset clear: hold rstn=0 for 3 cycles, then release.
  - Required: init_busy=1 for exactly 256 cycles, then 0.
  - Reading addresses 0, 128, 255 returns 0x00000000.
- Reset mid-clear: reassert rstn at clear cycle 100 for 1 cycle, then release.
  - Required: init_busy stays high for 256 further cycles.
  - A wr_en to addr 5 issued during busy has no effect; addr 5 reads 0.
- Byte-enable write: write 0xAABBCCDD to addr 0x10 with be=0xF, then 0x11223344 with be=0x5.
  - Required: read of addr 0x10 returns 0xAA22CC44.
- Latency: RD_LAT=1 and RD_LAT=2 builds, 4 back-to-back reads of addrs 1–4 preloaded with 0x1–0x4.
  - Required: rd_valid high for 4 consecutive cycles, starting 1 (resp. 2) cycles after the first rd_en.
  - Data is 0x1, 0x2, 0x3, 0x4 in order.
- Collision: preload addr 7=0x0000FFFF, then same cycle write 0x12345678 be=0xF and read addr 7.
  - Required: RDW_MODE=0 returns 0x0000FFFF; RDW_MODE=1 returns 0x12345678.
  - A subsequent read returns 0x12345678 in both modes.
- Parameter sweep: WIDTH=64, DEPTH=16, random writes and reads against a reference model for 2000 cycles.
  - Required: zero mismatches; rd_valid count equals accepted rd_en count.
